// File: rtl/brcomp_seq.sv
// brcomp_seq: sequential branch comparator.
// Compares two XLEN-bit operands CHUNK bits per cycle, starting with the most
// significant slice, and reports less-than (signed or unsigned) and equality.
// Optional feature macro: BRCOMP_EARLY_EXIT_EN -- when defined, the compare
// ends at the first differing slice; otherwise every slice is always examined
// so latency is constant. Both builds give identical results.
module brcomp_seq #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            br_unsigned_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            br_less_o,
  output logic            br_equal_o
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_less;
  logic              r_equal;
  logic [XLEN-1:0]   r_a;          // operand A, shifted left as slices are consumed
  logic [XLEN-1:0]   r_b;          // operand B, shifted in lock-step with r_a
  logic [CW-1:0]     r_cnt;        // slices still to examine, including the current one
  logic              r_decided;    // a differing slice has already been seen
  logic              r_less_acc;   // less-than verdict of that first differing slice

  logic [XLEN-1:0]   w_flip;
  logic [CHUNK-1:0]  w_slice_a;
  logic [CHUNK-1:0]  w_slice_b;
  logic              w_diff;
  logic              w_lt;
  logic              w_less_next;
  logic              w_dec_next;
  logic              w_last;
  logic              w_accept;

  // Signed compare maps onto unsigned by flipping the sign bit of both operands;
  // this mask holds a single 1 at the MSB when a signed compare is requested.
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_flip
    if (gi == XLEN - 1) begin : g_msb
      assign w_flip[gi] = ~br_unsigned_i;
    end else begin : g_low
      assign w_flip[gi] = 1'b0;
    end
  end

  // The slice under examination is always the top CHUNK bits of the shifters.
  assign w_slice_a = r_a[XLEN-1 -: CHUNK];
  assign w_slice_b = r_b[XLEN-1 -: CHUNK];
  assign w_diff    = (w_slice_a != w_slice_b);
  assign w_lt      = (w_slice_a < w_slice_b);

  // Once a differing slice has decided the result, lower slices cannot change it.
  assign w_less_next = r_decided ? r_less_acc : w_lt;
  assign w_dec_next  = r_decided | w_diff;

`ifdef BRCOMP_EARLY_EXIT_EN
  assign w_last = (r_cnt == CW'(1)) || w_diff;
`else
  assign w_last = (r_cnt == CW'(1));
`endif

  // A new operation can only be taken when not already comparing; flush wins.
  assign w_accept = start_i && !flush_i && (r_state != S_CMP);

  // Control FSM, operand shifters and registered result/status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_less     <= 1'b0;
      r_equal    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_decided  <= 1'b0;
      r_less_acc <= 1'b0;
    end else begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state    <= S_CMP;
            r_busy     <= 1'b1;
            r_a        <= rs1_data_i ^ w_flip;
            r_b        <= rs2_data_i ^ w_flip;
            r_cnt      <= CW'(NCHUNK);
            r_decided  <= 1'b0;
            r_less_acc <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CMP: begin
          if (flush_i) begin
            // Aborted: results keep the values of the last completed compare.
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_less  <= w_less_next;
            r_equal <= ~w_dec_next;
          end else begin
            r_busy     <= 1'b1;
            r_a        <= r_a << CHUNK;
            r_b        <= r_b << CHUNK;
            r_cnt      <= r_cnt - CW'(1);
            r_decided  <= w_dec_next;
            r_less_acc <= w_less_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign br_less_o  = r_less;
  assign br_equal_o = r_equal;

endmodule

// File: tb/tb_brcomp_seq.sv
// tb_brcomp_seq: randomized self-checking bench for brcomp_seq (XLEN=32, CHUNK=8).
// Expected results come from plain signed/unsigned arithmetic; expected latency
// comes from locating the most significant differing byte. Build with
// BRCOMP_EARLY_EXIT_EN defined to check the early-exit variant.
module tb_brcomp_seq;

  localparam int XLEN   = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = XLEN / CHUNK;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flush;
  logic            uns;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic            less;
  logic            equal;

  int n_checks = 0;
  int n_errors = 0;
  bit last_less;
  bit last_eq;

  brcomp_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .flush_i      (flush),
    .rs1_data_i   (rs1),
    .rs2_data_i   (rs2),
    .br_unsigned_i(uns),
    .busy_o       (busy),
    .done_o       (done),
    .br_less_o    (less),
    .br_equal_o   (equal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: what the comparison means arithmetically.
  function automatic bit ref_less(input bit [31:0] a, input bit [31:0] b, input bit u);
    if (u) return a < b;
    return $signed(a) < $signed(b);
  endfunction

  // Reference: cycles from the accepting edge until the result is shown.
  function automatic int ref_lat(input bit [31:0] a, input bit [31:0] b);
`ifdef BRCOMP_EARLY_EXIT_EN
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) return (NCHUNK - i) + 1;
    end
    return NCHUNK + 1;
`else
    return NCHUNK + 1;
`endif
  endfunction

  // Called #1 after an edge: request at the next edge, return #1 after it.
  task automatic launch(input bit [31:0] a, input bit [31:0] b, input bit u);
    start = 1'b1;
    rs1   = a;
    rs2   = b;
    uns   = u;
    @(posedge clk); #1;
    start = 1'b0;
    rs1   = ~a;             // operands must have been captured, so disturb them
    rs2   = $urandom;
    uns   = ~u;
    check("busy after start", 32'(busy), 32'd1);
  endtask

  // Wait for done (bounded), k0 = cycles already elapsed since acceptance.
  task automatic finish_op(input bit [31:0] a, input bit [31:0] b, input bit u,
                           input int k0, input string tag);
    int k;
    bit el;
    bit ee;
    k = k0;
    while (done !== 1'b1 && k < 4 * NCHUNK) begin
      @(posedge clk); #1;
      k++;
    end
    el = ref_less(a, b, u);
    ee = (a == b);
    check({tag, " latency"}, 32'(k), 32'(ref_lat(a, b)));
    check({tag, " less"}, 32'(less), 32'(el));
    check({tag, " equal"}, 32'(equal), 32'(ee));
    last_less = el;
    last_eq   = ee;
    $display("op %-10s a=%08h b=%08h uns=%0d less=%0d equal=%0d latency=%0d",
             tag, a, b, u, less, equal, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] a;
    bit [31:0] b;
    bit        u;
    bit        saw_done;
    int        ci;

    rst = 1'b1; start = 1'b0; flush = 1'b0; uns = 1'b0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset less", 32'(less), 32'd0);
    check("reset equal", 32'(equal), 32'd0);
    @(posedge clk); #1;

    // Directed cases.
    launch(32'h0000_0005, 32'h0000_0007, 1'b1);
    finish_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1, "5<7 u");
    @(posedge clk); #1;
    check("done one pulse", 32'(done), 32'd0);

    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    finish_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, "-1<1 s");
    @(posedge clk); #1;
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    finish_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, "ff..,1 u");
    @(posedge clk); #1;

    launch(32'h8000_0000, 32'h8000_0000, 1'b0);
    finish_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1, "eq 8000");
    @(posedge clk); #1;

    // Flush (with a simultaneous start that must be dropped) at T+2.
    launch(32'h1234_5678, 32'h1234_5679, 1'b1);
    @(posedge clk); #1;
    check("flush pre done", 32'(done), 32'd0);
    flush = 1'b1; start = 1'b1; rs1 = 32'h0; rs2 = 32'h1; uns = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    check("flush less kept", 32'(less), 32'(last_less));
    check("flush equal kept", 32'(equal), 32'(last_eq));
    $display("op %-10s a=12345678 b=12345679 aborted", "flush");
    launch(32'h0000_00FF, 32'h0000_0100, 1'b1);
    finish_op(32'h0000_00FF, 32'h0000_0100, 1'b1, 1, "post-flush");
    @(posedge clk); #1;

    // Start while busy is ignored; start in DONE is taken back-to-back.
    launch(32'h0000_0010, 32'h0000_0020, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; rs1 = 32'hFFFF_FFFF; rs2 = 32'h0; uns = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op(32'h0000_0010, 32'h0000_0020, 1'b1, 3, "busy-ign");
    launch(32'h0000_0020, 32'hFFFF_FF10, 1'b0);
    finish_op(32'h0000_0020, 32'hFFFF_FF10, 1'b0, 1, "b2b");

    // Randomized operations, often issued back-to-back from DONE.
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a;
        2: begin
          b  = a;
          ci = $urandom_range(0, NCHUNK - 1);
          b[ci*CHUNK +: CHUNK] = b[ci*CHUNK +: CHUNK] ^ 8'($urandom_range(1, 255));
        end
        default: b = a ^ 32'h8000_0000;
      endcase
      u = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk); #1;
        end
      end
      launch(a, b, u);
      finish_op(a, b, u, 1, "rnd");
    end
    @(posedge clk); #1;

    // Reset in the middle of an operation: no result may follow.
    launch(32'h0000_0001, 32'h0000_0002, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst less", 32'(less), 32'd0);
    check("midrst equal", 32'(equal), 32'd0);
    saw_done = 1'b0;
    repeat (2 * NCHUNK) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst no done", 32'(saw_done), 32'd0);
    $display("op %-10s a=00000001 b=00000002 aborted by reset", "reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/brcomp_seq.md
BRCOMP_SEQ -- requirements
Module: brcomp_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, bits compared per cycle; XLEN SHALL be an integer multiple of CHUNK, CHUNK >= 1.
REQ-003 The block SHALL derive NCHUNK = XLEN/CHUNK as a localparam.
REQ-004 The block SHALL use a single clock domain, clocked on the rising edge of clk_i; reset rst_i is synchronous and active-high.
REQ-005 The block SHALL have port clk_i, input, 1, clock.
REQ-006 The block SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port start_i, input, 1, request to begin a comparison.
REQ-008 The block SHALL have port flush_i, input, 1, abort an in-flight comparison.
REQ-009 The block SHALL have port rs1_data_i, input, XLEN, operand A.
REQ-010 The block SHALL have port rs2_data_i, input, XLEN, operand B.
REQ-011 The block SHALL have port br_unsigned_i, input, 1, 1 = unsigned compare, 0 = two's-complement signed compare.
REQ-012 The block SHALL have port busy_o, output, 1, comparison in progress.
REQ-013 The block SHALL have port done_o, output, 1, one-cycle result-valid pulse.
REQ-014 The block SHALL have port br_less_o, output, 1, A < B under the captured signedness.
REQ-015 The block SHALL have port br_equal_o, output, 1, A == B.

Function
REQ-016 The block SHALL implement FSM states IDLE, CMP and DONE, with busy_o = (state == CMP).
REQ-017 The block SHALL accept start_i only in IDLE or DONE, capturing rs1_data_i, rs2_data_i and br_unsigned_i at the accepting edge; start_i in CMP SHALL be ignored.
REQ-018 For a signed compare, the block SHALL invert bit XLEN-1 of both captured operands and then perform an unsigned compare.
REQ-019 In CMP, the block SHALL compare one CHUNK-wide slice per cycle, MSB slice first (index NCHUNK-1 down to 0).
REQ-020 At the first differing slice, the block SHALL latch less = (A slice < B slice) and equal = 0; lower slices SHALL NOT alter the decided result.
REQ-021 If no slice differs, the block SHALL record less = 0 and equal = 1.
REQ-022 The block SHALL transition CMP -> DONE after the final examined slice; DONE SHALL transition to IDLE, or to CMP if start_i is accepted.
REQ-023 If start is accepted at cycle T and N slices are examined, done_o SHALL be 1 only at cycle T+N+1, with br_less_o/br_equal_o updated in the same cycle.
REQ-024 br_less_o and br_equal_o SHALL hold their values until the next done_o pulse.
REQ-025 flush_i SHALL have priority over start_i: from CMP or DONE, next state is IDLE, no done_o is produced for the aborted operation, and outputs keep their prior values.
REQ-026 When flush_i and start_i are asserted in the same cycle, the start SHALL be dropped.
REQ-027 Back-to-back starts accepted in DONE SHALL yield a new result every N+1 cycles.

Reset
REQ-028 On rst_i = 1 at a clock edge, state SHALL become IDLE, and busy_o, done_o, br_less_o and br_equal_o SHALL all be 0.
REQ-029 rst_i SHALL take priority over flush_i and start_i, and SHALL abort any in-flight comparison without producing done_o.

Configuration
REQ-030 When macro BRCOMP_EARLY_EXIT_EN is defined, CMP SHALL end at the first differing slice, so N ranges from 1 to NCHUNK.
REQ-031 When BRCOMP_EARLY_EXIT_EN is undefined, CMP SHALL always examine all NCHUNK slices, so N = NCHUNK for constant latency, and the results SHALL be identical to the early-exit build.

Verification
REQ-032 The bench SHALL drive reset held for 2 cycles, then released, and check busy_o = done_o = br_less_o = br_equal_o = 0.
REQ-033 The bench SHALL drive XLEN=32, CHUNK=8, unsigned, A=0x0000_0005, B=0x0000_0007, and check done_o at T+5 with less=1, equal=0, in either build.
REQ-034 The bench SHALL drive a signed compare with A=0xFFFF_FFFF (-1), B=0x0000_0001, and check less=1; the same operands unsigned SHALL give less=0, with early exit at T+2.
REQ-035 The bench SHALL drive A=B=0x8000_0000, and check equal=1, less=0, with done_o at T+5 in both builds.
REQ-036 The bench SHALL assert flush_i at T+2 of an operation, and check that no done_o occurs and the outputs are unchanged; a start issued in the cycle after the flush SHALL complete normally.
REQ-037 The bench SHALL issue start_i while busy_o = 1, and check that it is ignored; a start in the DONE cycle SHALL be accepted back-to-back.
